cpu_regfile: RTL



---
 rtl/cpu_pkg.sv | 18 +
 rtl/rf_read_port.sv | 35 +++
 rtl/cpu_regfile.sv | 85 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register address/word types and
// the hardwired-zero register index. Used by the register file, ALU and decoder.
package cpu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // True when the address names the hardwired-zero register.
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: array select, zero forcing for
// register 0 and, when REGFILE_BYPASS_EN is defined, write-to-read forwarding
// so a dependent read sees the value being written in the same cycle.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::REG_ADDR_W,
  localparam int unsigned DEPTH = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] regs [DEPTH],
  output logic [DATA_W-1:0] rd
`ifdef REGFILE_BYPASS_EN
  ,
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
`endif
);

  // Select the addressed register; forward a pending write; force r0 to zero last.
  always_comb begin
    rd = regs[ra];
`ifdef REGFILE_BYPASS_EN
    if (byp_en && (wa == ra)) begin
      rd = wd;
    end
`endif
    if (ra == ADDR_W'(REG_ZERO)) begin
      rd = '0;
    end
  end

endmodule

// File: rtl/cpu_regfile.sv
// 32 x 32-bit general-purpose register file, two combinational read ports
// (ALU operand a / operand b) and one synchronous write port from writeback.
// Register 0 is hardwired to zero and has no storage.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q  [1:DEPTH-1];
  logic [DATA_W-1:0] rf_view [DEPTH];
  logic              wr_en;

  assign wr_en = we && (wa != ADDR_W'(REG_ZERO));

  // Storage: async clear of every register, commit qualified writes on the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wa] <= wd;
    end
  end

  // Full-depth view for the read ports; slot 0 is a constant zero.
  always_comb begin
    rf_view[0] = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so both ports read zero.
  logic byp_en;
  assign byp_en = wr_en && reset_n;
`endif

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port1 (
    .ra     (ra1),
    .regs   (rf_view),
    .rd     (rd1)
`ifdef REGFILE_BYPASS_EN
    ,
    .byp_en (byp_en),
    .wa     (wa),
    .wd     (wd)
`endif
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port2 (
    .ra     (ra2),
    .regs   (rf_view),
    .rd     (rd2)
`ifdef REGFILE_BYPASS_EN
    ,
    .byp_en (byp_en),
    .wa     (wa),
    .wd     (wd)
`endif
  );

endmodule
